lsu_iq_v2: RTL and testbench

Parametrised in-order issue queue for load/store micro-ops, sitting between dispatch and the DCache request port. It accepts up to `DISPATCH_WIDTH` memory ops per cycle into a circular buffer and captures missing operands from the CDB. It issues strictly in program order from the head. Each issued op gets address generation, byte-lane alignment and mask generation before a registered valid/ready request stage to the DCache.

---
 rtl/lsu_iq_v2.sv | 212 +++++++++++++++++++++
 tb/tb_lsu_iq_v2.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_iq_v2.sv
// In-order load/store issue queue: CDB operand capture, AGU, byte-lane alignment, registered DCache request.
// Optional feature macro: LSU_IQ_MISALIGN_CHK_EN (flag misaligned half/word accesses and suppress their masks).
module lsu_iq_v2 #(
   parameter int IQ_SIZE        = 8,
   parameter int DISPATCH_WIDTH = 2,
   parameter int CDB_COUNT      = 2,
   parameter int ROB_ID_W       = 6
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 flush,
   input  logic [DISPATCH_WIDTH-1:0]            disp_valid_i,
   output logic                                 disp_ready_o,
   input  logic [DISPATCH_WIDTH-1:0]            disp_wmem_i,
   input  logic [DISPATCH_WIDTH*2-1:0]          disp_msize_i,
   input  logic [DISPATCH_WIDTH*32-1:0]         disp_imm_i,
   input  logic [DISPATCH_WIDTH*ROB_ID_W-1:0]   disp_rob_id_i,
   input  logic [DISPATCH_WIDTH*64-1:0]         disp_src_data_i,
   input  logic [DISPATCH_WIDTH*2*ROB_ID_W-1:0] disp_src_tag_i,
   input  logic [DISPATCH_WIDTH*2-1:0]          disp_src_valid_i,
   input  logic [CDB_COUNT-1:0]                 cdb_valid_i,
   input  logic [CDB_COUNT*ROB_ID_W-1:0]        cdb_tag_i,
   input  logic [CDB_COUNT*32-1:0]              cdb_data_i,
   output logic                                 req_valid_o,
   input  logic                                 req_ready_i,
   output logic [31:0]                          req_vaddr_o,
   output logic [31:0]                          req_wdata_o,
   output logic [3:0]                           req_strb_o,
   output logic [3:0]                           req_rmask_o,
   output logic                                 req_wmem_o,
   output logic [1:0]                           req_msize_o,
   output logic [ROB_ID_W-1:0]                  req_rob_id_o,
   output logic                                 req_misalign_o,
   output logic [$clog2(IQ_SIZE):0]             occupancy_o
);
   localparam int PTR_W = $clog2(IQ_SIZE);
   localparam int OCC_W = PTR_W + 1;

   logic [IQ_SIZE-1:0]  ent_vld;
   logic                ent_wmem  [IQ_SIZE];
   logic [1:0]          ent_msize [IQ_SIZE];
   logic [31:0]         ent_imm   [IQ_SIZE];
   logic [ROB_ID_W-1:0] ent_rob   [IQ_SIZE];
   logic [1:0]          ent_rdy   [IQ_SIZE];
   logic [31:0]         ent_data  [IQ_SIZE][2];
   logic [ROB_ID_W-1:0] ent_tag   [IQ_SIZE][2];
   logic [32:0]         ent_cap   [IQ_SIZE][2];
   logic [32:0]         disp_cap  [DISPATCH_WIDTH][2];

   logic [PTR_W-1:0]          head, tail;
   logic [DISPATCH_WIDTH-1:0] lane_acc;
   logic [PTR_W-1:0]          lane_slot [DISPATCH_WIDTH];
   logic [OCC_W-1:0]          acc_cnt, occ_nxt;
   logic                      issue;

   logic [31:0] vaddr_p0, wdata_p0;
   logic [1:0]  off_p0;
   logic [3:0]  mask_p0, strb_p0, rmask_p0;
   logic        mis_p0;

   logic                vld_p1, wmem_p1, mis_p1;
   logic [31:0]         vaddr_p1, wdata_p1;
   logic [3:0]          strb_p1, rmask_p1;
   logic [1:0]          msize_p1;
   logic [ROB_ID_W-1:0] rob_p1;

   // {hit, data}; ports are scanned high to low so the lowest matching port wins.
   function automatic logic [32:0] cdb_match(input logic [ROB_ID_W-1:0] tag);
      logic [32:0] r;
      r = '0;
      for (int p = CDB_COUNT-1; p >= 0; p--)
         if (cdb_valid_i[p] && cdb_tag_i[p*ROB_ID_W +: ROB_ID_W] == tag)
            r = {1'b1, cdb_data_i[p*32 +: 32]};
      return r;
   endfunction

   function automatic logic [3:0] byte_mask(input logic [1:0] msize, input logic [1:0] off);
      case (msize)
         2'd0:    byte_mask = 4'b0001 << off;
         2'd1:    byte_mask = 4'b0011 << off;
         default: byte_mask = 4'hF;
      endcase
   endfunction

   always_comb begin
      for (int e = 0; e < IQ_SIZE; e++)
         for (int j = 0; j < 2; j++)
            ent_cap[e][j] = cdb_match(ent_tag[e][j]);
      for (int i = 0; i < DISPATCH_WIDTH; i++)
         for (int j = 0; j < 2; j++)
            disp_cap[i][j] = cdb_match(disp_src_tag_i[(2*i+j)*ROB_ID_W +: ROB_ID_W]);
   end

   // Valid lanes are packed into consecutive slots starting at tail.
   always_comb begin
      acc_cnt = '0;
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
         lane_acc[i]  = disp_valid_i[i] && disp_ready_o && !flush;
         lane_slot[i] = tail + acc_cnt[PTR_W-1:0];
         if (lane_acc[i])
            acc_cnt = acc_cnt + OCC_W'(1);
      end
   end

   assign issue   = ent_vld[head] && (&ent_rdy[head]) && (!vld_p1 || req_ready_i);
   assign occ_nxt = occupancy_o + acc_cnt - OCC_W'(issue);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent_vld      <= '0;
         head         <= '0;
         tail         <= '0;
         occupancy_o  <= '0;
         disp_ready_o <= 1'b1;
      end else if (flush) begin
         ent_vld      <= '0;
         head         <= '0;
         tail         <= '0;
         occupancy_o  <= '0;
         disp_ready_o <= 1'b1;
      end else begin
         if (issue)
            ent_vld[head] <= 1'b0;
         for (int i = 0; i < DISPATCH_WIDTH; i++)
            if (lane_acc[i])
               ent_vld[lane_slot[i]] <= 1'b1;
         head         <= head + PTR_W'(issue);
         tail         <= tail + acc_cnt[PTR_W-1:0];
         occupancy_o  <= occ_nxt;
         disp_ready_o <= (occ_nxt <= OCC_W'(IQ_SIZE - DISPATCH_WIDTH));
      end
   end

   // Entry payload: CDB wakeup for waiting operands, then dispatch writes into free slots.
   always_ff @(posedge clk) begin
      for (int e = 0; e < IQ_SIZE; e++)
         for (int j = 0; j < 2; j++)
            if (ent_vld[e] && !ent_rdy[e][j] && ent_cap[e][j][32]) begin
               ent_rdy[e][j]  <= 1'b1;
               ent_data[e][j] <= ent_cap[e][j][31:0];
            end
      for (int i = 0; i < DISPATCH_WIDTH; i++)
         if (lane_acc[i]) begin
            ent_wmem[lane_slot[i]]  <= disp_wmem_i[i];
            ent_msize[lane_slot[i]] <= disp_msize_i[2*i +: 2];
            ent_imm[lane_slot[i]]   <= disp_imm_i[32*i +: 32];
            ent_rob[lane_slot[i]]   <= disp_rob_id_i[ROB_ID_W*i +: ROB_ID_W];
            for (int j = 0; j < 2; j++) begin
               ent_tag[lane_slot[i]][j] <= disp_src_tag_i[(2*i+j)*ROB_ID_W +: ROB_ID_W];
               if (!disp_src_valid_i[2*i+j] && disp_cap[i][j][32]) begin
                  ent_rdy[lane_slot[i]][j]  <= 1'b1;
                  ent_data[lane_slot[i]][j] <= disp_cap[i][j][31:0];
               end else begin
                  ent_rdy[lane_slot[i]][j]  <= disp_src_valid_i[2*i+j];
                  ent_data[lane_slot[i]][j] <= disp_src_data_i[(2*i+j)*32 +: 32];
               end
            end
         end
   end

   // p0: address generation and lane alignment for the head entry
   always_comb begin
      vaddr_p0 = ent_data[head][1] + ent_imm[head];
      off_p0   = vaddr_p0[1:0];
      wdata_p0 = ent_data[head][0] << {off_p0, 3'b000};
      mask_p0  = byte_mask(ent_msize[head], off_p0);
`ifdef LSU_IQ_MISALIGN_CHK_EN
      mis_p0   = (ent_msize[head] == 2'd1 && off_p0[0]) || (ent_msize[head] == 2'd2 && off_p0 != 2'd0);
`else
      mis_p0   = 1'b0;
`endif
      strb_p0  = (ent_wmem[head] && !mis_p0) ? mask_p0 : 4'h0;
      rmask_p0 = (!ent_wmem[head] && !mis_p0) ? mask_p0 : 4'h0;
   end

   // p1: registered DCache request, held while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || flush) begin
         vld_p1   <= 1'b0;
         vaddr_p1 <= '0;
         wdata_p1 <= '0;
         strb_p1  <= '0;
         rmask_p1 <= '0;
         wmem_p1  <= 1'b0;
         msize_p1 <= '0;
         rob_p1   <= '0;
         mis_p1   <= 1'b0;
      end else if (issue) begin
         vld_p1   <= 1'b1;
         vaddr_p1 <= vaddr_p0;
         wdata_p1 <= wdata_p0;
         strb_p1  <= strb_p0;
         rmask_p1 <= rmask_p0;
         wmem_p1  <= ent_wmem[head];
         msize_p1 <= ent_msize[head];
         rob_p1   <= ent_rob[head];
         mis_p1   <= mis_p0;
      end else if (req_ready_i) begin
         vld_p1   <= 1'b0;
      end
   end

   assign req_valid_o    = vld_p1;
   assign req_vaddr_o    = vaddr_p1;
   assign req_wdata_o    = wdata_p1;
   assign req_strb_o     = strb_p1;
   assign req_rmask_o    = rmask_p1;
   assign req_wmem_o     = wmem_p1;
   assign req_msize_o    = msize_p1;
   assign req_rob_id_o   = rob_p1;
   assign req_misalign_o = mis_p1;
endmodule

// File: tb/tb_lsu_iq_v2.sv
// Testbench for lsu_iq_v2: vector table, directed multi-cycle sequences and a randomized scoreboard run.
module tb_lsu_iq_v2;
   localparam int IQ_SIZE = 8;
   localparam int DW      = 2;
   localparam int CDBN    = 2;
   localparam int RW      = 6;
`ifdef LSU_IQ_MISALIGN_CHK_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               flush = 1'b0;
   logic [DW-1:0]      disp_valid = '0;
   logic               disp_ready;
   logic [DW-1:0]      disp_wmem = '0;
   logic [DW*2-1:0]    disp_msize = '0;
   logic [DW*32-1:0]   disp_imm = '0;
   logic [DW*RW-1:0]   disp_rob = '0;
   logic [DW*64-1:0]   disp_sdata = '0;
   logic [DW*2*RW-1:0] disp_stag = '0;
   logic [DW*2-1:0]    disp_svalid = '0;
   logic [CDBN-1:0]    cdb_valid = '0;
   logic [CDBN*RW-1:0] cdb_tag = '0;
   logic [CDBN*32-1:0] cdb_data = '0;
   logic               req_valid;
   logic               req_ready = 1'b0;
   logic [31:0]        req_vaddr, req_wdata;
   logic [3:0]         req_strb, req_rmask;
   logic               req_wmem, req_mis;
   logic [1:0]         req_msize;
   logic [RW-1:0]      req_rob;
   logic [3:0]         occupancy;

   lsu_iq_v2 #(.IQ_SIZE(IQ_SIZE), .DISPATCH_WIDTH(DW), .CDB_COUNT(CDBN), .ROB_ID_W(RW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .disp_valid_i(disp_valid), .disp_ready_o(disp_ready), .disp_wmem_i(disp_wmem),
      .disp_msize_i(disp_msize), .disp_imm_i(disp_imm), .disp_rob_id_i(disp_rob),
      .disp_src_data_i(disp_sdata), .disp_src_tag_i(disp_stag), .disp_src_valid_i(disp_svalid),
      .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_data_i(cdb_data),
      .req_valid_o(req_valid), .req_ready_i(req_ready), .req_vaddr_o(req_vaddr),
      .req_wdata_o(req_wdata), .req_strb_o(req_strb), .req_rmask_o(req_rmask),
      .req_wmem_o(req_wmem), .req_msize_o(req_msize), .req_rob_id_o(req_rob),
      .req_misalign_o(req_mis), .occupancy_o(occupancy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] vaddr; logic [31:0] wdata; logic [3:0] strb; logic [3:0] rmask;
      logic wmem; logic [1:0] msize; logic [RW-1:0] rob; logic mis;
   } req_t;

   typedef struct {
      logic wm; logic [1:0] ms; logic [31:0] s0; logic [31:0] s1; logic [31:0] imm;
      logic [31:0] ev; logic [31:0] ew; logic [3:0] es; logic [3:0] er; logic em;
   } vec_t;

   typedef struct {
      logic wm; logic [1:0] ms; logic [31:0] imm; logic [31:0] s0; logic [31:0] s1; logic [RW-1:0] rob;
   } op_t;

   int          n_vec = 0;
   int          n_err = 0;
   int          n_acc = 0;
   int          n_hs  = 0;
   int          rob_ctr = 0;
   op_t         mq[$];
   logic [31:0] tagval [16];
   vec_t        tbl [9];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_req(input string name, input req_t act, input req_t exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic req_t cur_req();
      return req_t'({req_vaddr, req_wdata, req_strb, req_rmask, req_wmem, req_msize, req_rob, req_mis});
   endfunction

   // Reference request built directly from the address/mask rules.
   function automatic req_t exp_req(input op_t o);
      req_t r;
      logic [31:0] va;
      int off, nb;
      logic [3:0] m;
      logic mis;
      va  = o.s1 + o.imm;
      off = int'(va[1:0]);
      nb  = 1 << o.ms;
      m   = (o.ms >= 2) ? 4'hF : 4'(((1 << nb) - 1) << off);
      mis = MIS_EN && ((o.ms == 2'd1 && (off % 2) == 1) || (o.ms == 2'd2 && off != 0));
      r.vaddr = va;
      r.wdata = o.s0 << (8 * off);
      r.strb  = (o.wm && !mis) ? m : 4'h0;
      r.rmask = (!o.wm && !mis) ? m : 4'h0;
      r.wmem  = o.wm;
      r.msize = o.ms;
      r.rob   = o.rob;
      r.mis   = mis;
      return r;
   endfunction

   task automatic set_lane(input int l, input logic wm, input logic [1:0] ms, input logic [31:0] imm,
                           input logic [RW-1:0] rob, input logic [31:0] s0, input logic [31:0] s1,
                           input logic v0, input logic v1, input logic [RW-1:0] t0, input logic [RW-1:0] t1);
      disp_valid[l]               = 1'b1;
      disp_wmem[l]                = wm;
      disp_msize[l*2 +: 2]        = ms;
      disp_imm[l*32 +: 32]        = imm;
      disp_rob[l*RW +: RW]        = rob;
      disp_sdata[(2*l)*32 +: 32]  = s0;
      disp_sdata[(2*l+1)*32 +: 32] = s1;
      disp_svalid[2*l]            = v0;
      disp_svalid[2*l+1]          = v1;
      disp_stag[(2*l)*RW +: RW]   = t0;
      disp_stag[(2*l+1)*RW +: RW] = t1;
   endtask

   task automatic set_cdb(input int p, input logic [RW-1:0] t, input logic [31:0] d);
      cdb_valid[p]         = 1'b1;
      cdb_tag[p*RW +: RW]  = t;
      cdb_data[p*32 +: 32] = d;
   endtask

   task automatic rnd_cycle(input bit allow_disp, input int k);
      op_t lop [DW];
      op_t o;
      logic v0, v1, pre_dr, pre_rv;
      logic [RW-1:0] t0, t1, ct;
      logic [31:0] d0, d1;
      req_t pre_req;
      disp_valid = '0;
      cdb_valid  = '0;
      for (int l = 0; l < DW; l++) begin
         t0 = RW'($urandom_range(0, 15));
         t1 = RW'($urandom_range(0, 15));
         d0 = $urandom;
         d1 = $urandom;
         v0 = ($urandom_range(0, 3) != 0);
         v1 = ($urandom_range(0, 3) != 0);
         lop[l].wm  = 1'($urandom_range(0, 1));
         lop[l].ms  = 2'($urandom_range(0, 3));
         lop[l].imm = $urandom;
         lop[l].rob = RW'(rob_ctr);
         lop[l].s0  = v0 ? d0 : tagval[t0];
         lop[l].s1  = v1 ? d1 : tagval[t1];
         if (allow_disp && $urandom_range(0, 2) != 0) begin
            set_lane(l, lop[l].wm, lop[l].ms, lop[l].imm, lop[l].rob, d0, d1, v0, v1, t0, t1);
            rob_ctr++;
         end
      end
      for (int p = 0; p < CDBN; p++) begin
         if (allow_disp) begin
            if ($urandom_range(0, 1) != 0) begin
               ct = RW'($urandom_range(0, 15));
               set_cdb(p, ct, tagval[ct]);
            end
         end else begin
            ct = RW'((k + 8 * p) % 16);
            set_cdb(p, ct, tagval[ct]);
         end
      end
      req_ready = allow_disp ? ($urandom_range(0, 3) != 0) : 1'b1;
      pre_dr  = disp_ready;
      pre_rv  = req_valid;
      pre_req = cur_req();
      tick();
      if (pre_dr)
         for (int l = 0; l < DW; l++)
            if (disp_valid[l]) begin
               mq.push_back(lop[l]);
               n_acc++;
            end
      if (pre_rv && req_ready) begin
         if (mq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL rnd_extra_req: got rob %0d expected no request", pre_req.rob);
         end else begin
            o = mq.pop_front();
            check_req("rnd_req", pre_req, exp_req(o));
         end
         n_hs++;
      end else if (pre_rv) begin
         check("rnd_hold_v", req_valid, 1);
         check_req("rnd_hold", cur_req(), pre_req);
      end
      check("rnd_occ", 64'(int'(occupancy) + int'(req_valid)), 64'(n_acc - n_hs));
      check("rnd_rdy", disp_ready, (IQ_SIZE - int'(occupancy)) >= DW);
   endtask

   initial begin
      tbl[0] = '{1'b0, 2'd2, 32'h0,        32'h1000,     32'h4,        32'h1004, 32'h0,        4'h0, 4'hF, 1'b0};
      tbl[1] = '{1'b0, 2'd2, 32'h0,        32'h1000,     32'h8,        32'h1008, 32'h0,        4'h0, 4'hF, 1'b0};
      tbl[2] = '{1'b1, 2'd0, 32'hAB,       32'h2001,     32'h2,        32'h2003, 32'hAB000000, 4'h8, 4'h0, 1'b0};
      tbl[3] = '{1'b0, 2'd1, 32'h11223344, 32'h3000,     32'h1,        32'h3001, 32'h22334400, 4'h0, MIS_EN ? 4'h0 : 4'h6, MIS_EN};
      tbl[4] = '{1'b1, 2'd1, 32'hBEEF,     32'hFFFFFFFE, 32'h4,        32'h2,    32'hBEEF0000, 4'hC, 4'h0, 1'b0};
      tbl[5] = '{1'b1, 2'd2, 32'hDEADBEEF, 32'h100,      32'hFFFFFFFF, 32'hFF,   32'hEF000000, MIS_EN ? 4'h0 : 4'hF, 4'h0, MIS_EN};
      tbl[6] = '{1'b0, 2'd0, 32'h0,        32'h40,       32'h3,        32'h43,   32'h0,        4'h0, 4'h8, 1'b0};
      tbl[7] = '{1'b1, 2'd1, 32'h1234,     32'h3,        32'h0,        32'h3,    32'h34000000, MIS_EN ? 4'h0 : 4'h8, 4'h0, MIS_EN};
      tbl[8] = '{1'b0, 2'd3, 32'hFF,       32'h10,       32'h2,        32'h12,   32'h00FF0000, 4'h0, 4'hF, 1'b0};
      for (int t = 0; t < 16; t++)
         tagval[t] = $urandom;

      // Reset state
      tick(); tick();
      check("rst_valid", req_valid, 0);
      check("rst_occ", occupancy, 0);
      check("rst_ready", disp_ready, 1);
      check_req("rst_req", cur_req(), '0);
      rst_n = 1'b1;
      tick();

      // Single ops from the table: latency and alignment
      for (int i = 0; i < 9; i++) begin
         set_lane(0, tbl[i].wm, tbl[i].ms, tbl[i].imm, RW'(i + 1), tbl[i].s0, tbl[i].s1, 1'b1, 1'b1, '0, '0);
         tick();
         disp_valid = '0;
         check($sformatf("tbl%0d_e0_valid", i), req_valid, 0);
         tick();
         check($sformatf("tbl%0d_e1_valid", i), req_valid, 1);
         check_req($sformatf("tbl%0d_req", i), cur_req(),
                   req_t'({tbl[i].ev, tbl[i].ew, tbl[i].es, tbl[i].er, tbl[i].wm, tbl[i].ms, RW'(i + 1), tbl[i].em}));
         req_ready = 1'b1;
         tick();
         req_ready = 1'b0;
         check($sformatf("tbl%0d_done", i), req_valid, 0);
      end

      // Two loads in one dispatch cycle, back-to-back requests
      req_ready = 1'b1;
      set_lane(0, 1'b0, 2'd2, 32'h4, 6'd10, 32'h0, 32'h1000, 1'b1, 1'b1, '0, '0);
      set_lane(1, 1'b0, 2'd2, 32'h8, 6'd11, 32'h0, 32'h1000, 1'b1, 1'b1, '0, '0);
      tick();
      disp_valid = '0;
      check("dual_occ", occupancy, 2);
      tick();
      check_req("dual_req0", cur_req(), req_t'({32'h1004, 32'h0, 4'h0, 4'hF, 1'b0, 2'd2, 6'd10, 1'b0}));
      check("dual_v0", req_valid, 1);
      tick();
      check_req("dual_req1", cur_req(), req_t'({32'h1008, 32'h0, 4'h0, 4'hF, 1'b0, 2'd2, 6'd11, 1'b0}));
      check("dual_v1", req_valid, 1);
      tick();
      check("dual_done", req_valid, 0);

      // Store waiting on tag 5; both CDB ports carry tag 5, port 0 must win
      set_lane(0, 1'b1, 2'd0, 32'h2, 6'd12, 32'hAB, 32'hFFFF0000, 1'b1, 1'b0, 6'd0, 6'd5);
      tick();
      disp_valid = '0;
      check("cdb_wait0", req_valid, 0);
      tick();
      check("cdb_wait1", req_valid, 0);
      set_cdb(0, 6'd5, 32'h2001);
      set_cdb(1, 6'd5, 32'h7777);
      tick();
      cdb_valid = '0;
      check("cdb_wait2", req_valid, 0);
      tick();
      check("cdb_issue", req_valid, 1);
      check_req("cdb_req", cur_req(), req_t'({32'h2003, 32'hAB000000, 4'h8, 4'h0, 1'b1, 2'd0, 6'd12, 1'b0}));
      tick();
      check("cdb_done", req_valid, 0);

      // Dispatch-cycle bypass from CDB port 1, lane 1 only (lane 0 idle)
      set_lane(1, 1'b0, 2'd2, 32'h10, 6'd13, 32'h0, 32'hDEAD0000, 1'b1, 1'b0, 6'd0, 6'd9);
      set_cdb(0, 6'd3, 32'h123);
      set_cdb(1, 6'd9, 32'h500);
      tick();
      disp_valid = '0;
      cdb_valid  = '0;
      tick();
      check("byp_issue", req_valid, 1);
      check_req("byp_req", cur_req(), req_t'({32'h510, 32'h0, 4'h0, 4'hF, 1'b0, 2'd2, 6'd13, 1'b0}));
      tick();
      check("byp_done", req_valid, 0);

      // Backpressure: three ready entries, stage held for five cycles
      req_ready = 1'b0;
      set_lane(0, 1'b0, 2'd2, 32'h0, 6'd20, 32'h0, 32'h100, 1'b1, 1'b1, '0, '0);
      set_lane(1, 1'b0, 2'd2, 32'h0, 6'd21, 32'h0, 32'h200, 1'b1, 1'b1, '0, '0);
      tick();
      disp_valid = '0;
      set_lane(0, 1'b0, 2'd2, 32'h0, 6'd22, 32'h0, 32'h300, 1'b1, 1'b1, '0, '0);
      tick();
      disp_valid = '0;
      for (int k = 0; k < 5; k++) begin
         check_req($sformatf("hold_req%0d", k), cur_req(), req_t'({32'h100, 32'h0, 4'h0, 4'hF, 1'b0, 2'd2, 6'd20, 1'b0}));
         check($sformatf("hold_occ%0d", k), occupancy, 2);
         tick();
      end
      req_ready = 1'b1;
      tick();
      check_req("rel_req1", cur_req(), req_t'({32'h200, 32'h0, 4'h0, 4'hF, 1'b0, 2'd2, 6'd21, 1'b0}));
      tick();
      check_req("rel_req2", cur_req(), req_t'({32'h300, 32'h0, 4'h0, 4'hF, 1'b0, 2'd2, 6'd22, 1'b0}));
      check("rel_v2", req_valid, 1);
      tick();
      check("rel_done", req_valid, 0);
      check("rel_occ", occupancy, 0);

      // Fill with operands that never arrive: 1 + 2 + 2 + 2 entries
      req_ready = 1'b0;
      set_lane(0, 1'b0, 2'd2, 32'h0, 6'd30, 32'h0, 32'h0, 1'b1, 1'b0, 6'd0, 6'd20);
      tick();
      disp_valid = '0;
      check("fill_occ1", occupancy, 1);
      for (int k = 0; k < 3; k++) begin
         set_lane(0, 1'b0, 2'd2, 32'h0, RW'(31 + 2*k), 32'h0, 32'h0, 1'b1, 1'b0, 6'd0, RW'(21 + 2*k));
         set_lane(1, 1'b0, 2'd2, 32'h0, RW'(32 + 2*k), 32'h0, 32'h0, 1'b1, 1'b0, 6'd0, RW'(22 + 2*k));
         tick();
         disp_valid = '0;
         check($sformatf("fill_occ%0d", 3 + 2*k), occupancy, 64'(3 + 2*k));
         check($sformatf("fill_rdy%0d", 3 + 2*k), disp_ready, (k < 2) ? 1 : 0);
      end
      set_lane(0, 1'b0, 2'd2, 32'h0, 6'd50, 32'h0, 32'h0, 1'b1, 1'b1, '0, '0);
      set_lane(1, 1'b0, 2'd2, 32'h0, 6'd51, 32'h0, 32'h0, 1'b1, 1'b1, '0, '0);
      tick();
      disp_valid = '0;
      check("full_reject_occ", occupancy, 7);
      set_cdb(0, 6'd20, 32'h4000);
      tick();
      cdb_valid = '0;
      check("full_cap_occ", occupancy, 7);
      check("full_cap_rdy", disp_ready, 0);
      check("full_cap_v", req_valid, 0);
      tick();
      check("full_iss_occ", occupancy, 6);
      check("full_iss_rdy", disp_ready, 1);
      check("full_iss_v", req_valid, 1);
      check("full_iss_rob", req_rob, 30);

      // Flush beats a same-cycle dispatch and CDB wakeup
      flush = 1'b1;
      set_lane(0, 1'b0, 2'd2, 32'h0, 6'd41, 32'h0, 32'h0, 1'b1, 1'b1, '0, '0);
      set_cdb(0, 6'd21, 32'h0);
      tick();
      flush      = 1'b0;
      disp_valid = '0;
      cdb_valid  = '0;
      check("flush_v", req_valid, 0);
      check("flush_occ", occupancy, 0);
      check("flush_rdy", disp_ready, 1);
      check_req("flush_req", cur_req(), '0);
      for (int k = 0; k < 4; k++) begin
         set_cdb(0, RW'(21 + 2*k), 32'h0);
         set_cdb(1, RW'(22 + 2*k), 32'h0);
         tick();
         cdb_valid = '0;
         check($sformatf("flush_stale%0d", k), req_valid, 0);
      end
      req_ready = 1'b1;
      set_lane(0, 1'b0, 2'd2, 32'h0, 6'd40, 32'h0, 32'h40, 1'b1, 1'b1, '0, '0);
      tick();
      disp_valid = '0;
      check("post_flush_occ", occupancy, 1);
      tick();
      check_req("post_flush_req", cur_req(), req_t'({32'h40, 32'h0, 4'h0, 4'hF, 1'b0, 2'd2, 6'd40, 1'b0}));
      tick();
      check("post_flush_done", req_valid, 0);

      // Asynchronous reset drops an outstanding request without a clock edge
      req_ready = 1'b0;
      set_lane(0, 1'b1, 2'd2, 32'h0, 6'd42, 32'h55, 32'h80, 1'b1, 1'b1, '0, '0);
      tick();
      disp_valid = '0;
      tick();
      check("arst_pre_v", req_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_v", req_valid, 0);
      check("arst_occ", occupancy, 0);
      check_req("arst_req", cur_req(), '0);
      tick();
      rst_n = 1'b1;
      tick();

      // Randomized traffic against the scoreboard, then drain
      for (int c = 0; c < 2500; c++)
         rnd_cycle(1'b1, c);
      for (int c = 0; c < 400 && (mq.size() != 0 || req_valid); c++)
         rnd_cycle(1'b0, c);
      check("drain_empty", 64'(mq.size()), 0);
      check("drain_valid", req_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
